// File: rtl/prog_run_pkg.sv
`default_nettype none
// prog_run_pkg: shared state encoding, default parameters and window type for prog_run_checker.
package prog_run_pkg;

  localparam int DEF_NUM_PROG  = 3;
  localparam int DEF_AW        = 8;
  localparam int DEF_DW        = 8;
  localparam int DEF_START_CYC = 1;
  localparam int DEF_TIMEOUT   = 65535;
  localparam int DEF_CYC_W     = 16;
  localparam int DEF_ERR_W     = 16;

  // Window bounds are carried zero-extended to a fixed width so one struct serves any AW <= WIN_W.
  localparam int WIN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_CHECK    = 3'd3,
    S_NEXT     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  typedef struct packed {
    logic [WIN_W-1:0] lo;
    logic [WIN_W-1:0] hi;
  } win_t;

endpackage
`default_nettype wire

// File: rtl/mem_window_compare.sv
`default_nettype none
// mem_window_compare: walks an inclusive address window, compares DUT against golden data,
// counts mismatches (saturating) and captures the first mismatch of the run.
module mem_window_compare
  import prog_run_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int ERR_W = DEF_ERR_W,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             active,
  input  logic [PW-1:0]    prog,
  input  win_t             win,
  input  logic [DW-1:0]    dut_data,
  input  logic [DW-1:0]    gold_data,
  output logic [AW-1:0]    addr,
  output logic             last,
  output logic             prog_err,
  output logic [ERR_W-1:0] err_count,
  output logic             first_valid,
  output logic [PW-1:0]    first_prog,
  output logic [AW-1:0]    first_addr,
  output logic [DW-1:0]    first_exp,
  output logic [DW-1:0]    first_got
);

  logic [WIN_W-1:0] addr_ext;
  logic             empty;
  logic             mismatch;

  assign addr_ext = WIN_W'(addr);
  assign empty    = (win.lo > win.hi);
  // Stopping on equality with hi (rather than incrementing past it) keeps 2^AW-1 from wrapping.
  assign last     = empty || (addr_ext == win.hi);
  assign mismatch = active && !empty && (dut_data != gold_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr        <= '0;
      prog_err    <= 1'b0;
      err_count   <= '0;
      first_valid <= 1'b0;
      first_prog  <= '0;
      first_addr  <= '0;
      first_exp   <= '0;
      first_got   <= '0;
    end else begin
      if (clear) begin
        prog_err    <= 1'b0;
        err_count   <= '0;
        first_valid <= 1'b0;
        first_prog  <= '0;
        first_addr  <= '0;
        first_exp   <= '0;
        first_got   <= '0;
      end
      if (load) begin
        addr     <= win.lo[AW-1:0];
        prog_err <= 1'b0;
      end else if (active && !last) begin
        addr <= addr + 1'b1;
      end
      if (mismatch) begin
        prog_err <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
        if (!first_valid) begin
          first_valid <= 1'b1;
          first_prog  <= prog;
          first_addr  <= addr;
          first_exp   <= gold_data;
          first_got   <= dut_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_run_checker.sv
`default_nettype none
// prog_run_checker: runs NUM_PROG programs back-to-back (Start/Ack with timeout) and checks
// each program's data-memory window against a golden image.
module prog_run_checker
  import prog_run_pkg::*;
#(
  parameter int NUM_PROG  = DEF_NUM_PROG,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int START_CYC = DEF_START_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CYC_W     = DEF_CYC_W,
  parameter int ERR_W     = DEF_ERR_W,
  localparam int PW       = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Go,
  input  logic [NUM_PROG*AW-1:0] WinLo,
  input  logic [NUM_PROG*AW-1:0] WinHi,
  output logic                   Start,
  input  logic                   Ack,
  output logic [AW-1:0]          DutAddr,
  output logic [AW-1:0]          GoldAddr,
  input  logic [DW-1:0]          DutData,
  input  logic [DW-1:0]          GoldData,
  output logic                   Busy,
  output logic                   Done,
  output logic [PW-1:0]          ProgIdx,
  output logic [NUM_PROG-1:0]    PassMask,
  output logic [NUM_PROG-1:0]    TimeoutMask,
  output logic [ERR_W-1:0]       ErrCount,
  output logic                   FirstErrValid,
  output logic [PW-1:0]          FirstErrProg,
  output logic [AW-1:0]          FirstErrAddr,
  output logic [DW-1:0]          FirstErrExp,
  output logic [DW-1:0]          FirstErrGot,
  output logic [CYC_W-1:0]       LastCycles
);

  state_t              state, next_state;
  logic [PW-1:0]       prog_idx;
  logic [NUM_PROG-1:0] pass_mask, timeout_mask;
  logic [CYC_W-1:0]    cyc_cnt, cyc_inc, last_cycles;
  logic                ack_low_seen;
  logic                ack_ok, timeout_hit, start_done, last_prog, go_accept;
  logic                chk_last, prog_err, chk_load, chk_active;
  logic [AW-1:0]       addr;
  win_t                cur_win;

  // Ack only counts once it has been seen low in this program, so a level left over
  // from the previous program cannot complete the handshake.
  assign ack_ok      = Ack && ack_low_seen;
  assign cyc_inc     = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 1'b1;
  assign timeout_hit = (32'(cyc_cnt) >= 32'(TIMEOUT));
  assign start_done  = (32'(cyc_cnt) >= 32'(START_CYC));
  assign last_prog   = (prog_idx == PW'(NUM_PROG - 1));
  assign go_accept   = ((state == S_IDLE) || (state == S_DONE)) && Go;
  assign chk_load    = (state == S_WAIT_ACK) && ack_ok;
  assign chk_active  = (state == S_CHECK);

  always_comb begin
    cur_win    = '0;
    cur_win.lo = WIN_W'(WinLo[int'(prog_idx)*AW +: AW]);
    cur_win.hi = WIN_W'(WinHi[int'(prog_idx)*AW +: AW]);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    Start      = 1'b0;
    Busy       = 1'b1;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Go) next_state = S_START;
      end
      S_START: begin
        Start = 1'b1;
        if (start_done) next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_ok)           next_state = S_CHECK;
        else if (timeout_hit) next_state = S_NEXT;
      end
      S_CHECK: begin
        if (chk_last) next_state = S_NEXT;
      end
      S_NEXT: begin
        next_state = last_prog ? S_DONE : S_START;
      end
      S_DONE: begin
        Busy = 1'b0;
        Done = 1'b1;
        if (Go) next_state = S_START;
      end
      default: begin
        next_state = S_IDLE;
        Busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prog_idx     <= '0;
      pass_mask    <= '0;
      timeout_mask <= '0;
      cyc_cnt      <= '0;
      last_cycles  <= '0;
      ack_low_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Go) begin
            prog_idx     <= '0;
            pass_mask    <= '0;
            timeout_mask <= '0;
            cyc_cnt      <= CYC_W'(1);
            ack_low_seen <= 1'b0;
          end
        end
        S_START, S_WAIT_ACK: begin
          cyc_cnt <= cyc_inc;
          if (!Ack) ack_low_seen <= 1'b1;
          if (state == S_WAIT_ACK) begin
            if (ack_ok)           last_cycles <= cyc_cnt;
            else if (timeout_hit) timeout_mask[prog_idx] <= 1'b1;
          end
        end
        S_NEXT: begin
          if (!timeout_mask[prog_idx] && !prog_err) pass_mask[prog_idx] <= 1'b1;
          if (!last_prog) begin
            prog_idx     <= prog_idx + 1'b1;
            cyc_cnt      <= CYC_W'(1);
            ack_low_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  mem_window_compare #(
    .AW    (AW),
    .DW    (DW),
    .ERR_W (ERR_W),
    .PW    (PW)
  ) u_cmp (
    .clk         (Clk),
    .rst_n       (Reset),
    .clear       (go_accept),
    .load        (chk_load),
    .active      (chk_active),
    .prog        (prog_idx),
    .win         (cur_win),
    .dut_data    (DutData),
    .gold_data   (GoldData),
    .addr        (addr),
    .last        (chk_last),
    .prog_err    (prog_err),
    .err_count   (ErrCount),
    .first_valid (FirstErrValid),
    .first_prog  (FirstErrProg),
    .first_addr  (FirstErrAddr),
    .first_exp   (FirstErrExp),
    .first_got   (FirstErrGot)
  );

  assign DutAddr     = addr;
  assign GoldAddr    = addr;
  assign ProgIdx     = prog_idx;
  assign PassMask    = pass_mask;
  assign TimeoutMask = timeout_mask;
  assign LastCycles  = last_cycles;

endmodule
`default_nettype wire

// File: tb/tb_prog_run_checker.sv
`default_nettype none
// tb_prog_run_checker: directed bench with an Ack stub and DUT/golden memory models.
module tb_prog_run_checker;

  localparam int NP      = 3;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int ACK_DLY = 20;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Go;
  logic [NP*AW-1:0] WinLo, WinHi;
  logic           Start;
  logic           Ack;
  logic [AW-1:0]  DutAddr, GoldAddr;
  logic [DW-1:0]  DutData, GoldData;
  logic           Busy, Done;
  logic [1:0]     ProgIdx;
  logic [NP-1:0]  PassMask, TimeoutMask;
  logic [15:0]    ErrCount;
  logic           FirstErrValid;
  logic [1:0]     FirstErrProg;
  logic [AW-1:0]  FirstErrAddr;
  logic [DW-1:0]  FirstErrExp, FirstErrGot;
  logic [15:0]    LastCycles;

  logic [DW-1:0]  dut_mem  [256];
  logic [DW-1:0]  gold_mem [256];
  int             scnt       = 0;
  int             hang_prog  = -1;
  int             stale_hold = 0;
  int             tests_run  = 0;
  int             tests_failed = 0;

  always #5 Clk = ~Clk;

  prog_run_checker #(
    .NUM_PROG (NP), .AW (AW), .DW (DW), .START_CYC (1),
    .TIMEOUT (100), .CYC_W (16), .ERR_W (16)
  ) dut (
    .Clk (Clk), .Reset (Reset), .Go (Go), .WinLo (WinLo), .WinHi (WinHi),
    .Start (Start), .Ack (Ack), .DutAddr (DutAddr), .GoldAddr (GoldAddr),
    .DutData (DutData), .GoldData (GoldData), .Busy (Busy), .Done (Done),
    .ProgIdx (ProgIdx), .PassMask (PassMask), .TimeoutMask (TimeoutMask),
    .ErrCount (ErrCount), .FirstErrValid (FirstErrValid), .FirstErrProg (FirstErrProg),
    .FirstErrAddr (FirstErrAddr), .FirstErrExp (FirstErrExp), .FirstErrGot (FirstErrGot),
    .LastCycles (LastCycles)
  );

  always_comb DutData  = dut_mem[DutAddr];
  always_comb GoldData = gold_mem[GoldAddr];

  // Stub core: Ack rises ACK_DLY cycles after Start (counting the Start cycle), optionally
  // holds a stale high for stale_hold cycles, and never acks for hang_prog.
  always @(posedge Clk) begin
    if (Start)                          scnt <= 1;
    else if (scnt != 0 && scnt < 100000) scnt <= scnt + 1;
  end
  always_comb begin
    Ack = 1'b0;
    if (hang_prog != int'(ProgIdx))
      Ack = (scnt >= ACK_DLY - 1) || (scnt < stale_hold);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_reset();
    for (int a = 0; a < 256; a++) begin
      gold_mem[a] = 8'(a) ^ 8'hC3;
      dut_mem[a]  = 8'(a) ^ 8'hC3;
    end
  endtask

  task automatic start_run();
    Go = 1'b1;
    @(posedge Clk); #1;
    Go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (Done) break;
      @(posedge Clk); #1;
    end
    check(tag, 32'(Done), 32'd1);
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_start"},   32'(Start), 0);
    check({p, "_busy"},    32'(Busy), 0);
    check({p, "_done"},    32'(Done), 0);
    check({p, "_progidx"}, 32'(ProgIdx), 0);
    check({p, "_pass"},    32'(PassMask), 0);
    check({p, "_tmo"},     32'(TimeoutMask), 0);
    check({p, "_errcnt"},  32'(ErrCount), 0);
    check({p, "_fev"},     32'(FirstErrValid), 0);
    check({p, "_feaddr"},  32'(FirstErrAddr), 0);
    check({p, "_addr"},    32'(DutAddr), 0);
    check({p, "_cycles"},  32'(LastCycles), 0);
  endtask

  initial begin
    Reset = 1'b0;
    Go    = 1'b0;
    WinLo = {8'd192, 8'd94, 8'd30};
    WinHi = {8'd194, 8'd123, 8'd59};
    mem_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_reset_state("rst");
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Clean run, with handshake and first-address latency checks on program 0.
    start_run();
    check("go_start", 32'(Start), 1);
    check("go_busy",  32'(Busy), 1);
    for (int i = 0; i < 100; i++) begin
      if (Ack) break;
      @(posedge Clk); #1;
    end
    @(posedge Clk); #1;
    check("first_addr",  32'(DutAddr), 32'd30);
    check("p0_cycles",   32'(LastCycles), 32'd20);
    wait_done("t1_done");
    check("t1_busy",   32'(Busy), 0);
    check("t1_pass",   32'(PassMask), 32'b111);
    check("t1_err",    32'(ErrCount), 0);
    check("t1_tmo",    32'(TimeoutMask), 0);
    check("t1_fev",    32'(FirstErrValid), 0);
    check("t1_cycles", 32'(LastCycles), 32'd20);

    // Two corrupted words, one in program 0 and one in program 2.
    gold_mem[40] = 8'h00; dut_mem[40] = 8'h5A;
    gold_mem[193] = 8'h00; dut_mem[193] = 8'h01;
    start_run();
    wait_done("t2_done");
    check("t2_err",   32'(ErrCount), 32'd2);
    check("t2_fev",   32'(FirstErrValid), 1);
    check("t2_fprog", 32'(FirstErrProg), 0);
    check("t2_faddr", 32'(FirstErrAddr), 32'd40);
    check("t2_fexp",  32'(FirstErrExp), 32'h00);
    check("t2_fgot",  32'(FirstErrGot), 32'h5A);
    check("t2_pass",  32'(PassMask), 32'b010);
    mem_reset();

    // Program 1 hangs; program 2 must still run.
    hang_prog = 1;
    start_run();
    wait_done("t3_done");
    check("t3_tmo",    32'(TimeoutMask), 32'b010);
    check("t3_pass",   32'(PassMask), 32'b101);
    check("t3_err",    32'(ErrCount), 0);
    check("t3_cycles", 32'(LastCycles), 32'd20);
    hang_prog = -1;

    // Stale Ack held across START must not be taken; Go mid-run is ignored.
    stale_hold = 5;
    start_run();
    for (int i = 0; i < 500; i++) begin
      if (ProgIdx == 2'd1) break;
      @(posedge Clk); #1;
    end
    check("t4_p0_cycles", 32'(LastCycles), 32'd20);
    start_run();
    check("t4_go_busy_prog", 32'(ProgIdx), 32'd1);
    wait_done("t4_done");
    check("t4_pass",   32'(PassMask), 32'b111);
    check("t4_cycles", 32'(LastCycles), 32'd20);
    stale_hold = 0;

    // Window reaching the top of the address space, and an empty window.
    WinLo = {8'd30, 8'd10, 8'd250};
    WinHi = {8'd32, 8'd5, 8'd255};
    for (int a = 250; a < 256; a++) dut_mem[a] = gold_mem[a] ^ 8'h01;
    for (int a = 5; a <= 10; a++)   dut_mem[a] = gold_mem[a] ^ 8'h01;
    dut_mem[0] = gold_mem[0] ^ 8'h01;
    start_run();
    wait_done("t5_done");
    check("t5_err",   32'(ErrCount), 32'd6);
    check("t5_pass",  32'(PassMask), 32'b110);
    check("t5_fprog", 32'(FirstErrProg), 0);
    check("t5_faddr", 32'(FirstErrAddr), 32'd250);
    check("t5_fexp",  32'(FirstErrExp), 32'h39);
    check("t5_fgot",  32'(FirstErrGot), 32'h38);
    mem_reset();

    // Reset in the middle of CHECK, then a fresh clean run.
    WinLo = {8'd192, 8'd94, 8'd30};
    WinHi = {8'd194, 8'd123, 8'd59};
    gold_mem[45] = 8'h11; dut_mem[45] = 8'h22;
    start_run();
    for (int i = 0; i < 500; i++) begin
      if (Busy && DutAddr == 8'd50) break;
      @(posedge Clk); #1;
    end
    check("t6_pre_addr", 32'(DutAddr), 32'd50);
    check("t6_pre_err",  32'(ErrCount), 32'd1);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_reset_state("t6_rst");
    Reset = 1'b1;
    mem_reset();
    @(posedge Clk); #1;
    start_run();
    wait_done("t6_done");
    check("t6_pass", 32'(PassMask), 32'b111);
    check("t6_err",  32'(ErrCount), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
